// File: rtl/bp_fe_ras_ckpt.sv
// bp_fe_ras_ckpt: front-end return-address stack with in-order checkpoints and one-cycle restore.
// Optional macro BP_FE_RAS_CKPT_BACKUP_EN: when the stack is empty, pop_pc_o shows the last pushed address.
module bp_fe_ras_ckpt #(
    parameter int vaddr_width_p    = 39,
    parameter int ras_els_p        = 8,
    parameter int ckpt_els_p       = 4,
    parameter int ckpt_id_width_lp = (ckpt_els_p > 1) ? $clog2(ckpt_els_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        push_v_i,
    input  logic [vaddr_width_p-1:0]    push_pc_i,
    input  logic                        pop_v_i,
    output logic [vaddr_width_p-1:0]    pop_pc_o,
    output logic                        pop_pc_v_o,
    input  logic                        ckpt_v_i,
    output logic                        ckpt_ready_o,
    output logic [ckpt_id_width_lp-1:0] ckpt_id_o,
    input  logic                        commit_v_i,
    input  logic                        restore_v_i,
    input  logic [ckpt_id_width_lp-1:0] restore_id_i
);

    localparam int ptr_w_lp = (ras_els_p > 1) ? $clog2(ras_els_p) : 1;
    localparam int cnt_w_lp = $clog2(ras_els_p + 1);
    localparam int qp_w_lp  = ckpt_id_width_lp + 1;

    logic [ptr_w_lp-1:0]      ptr_r, ptr_n;
    logic [cnt_w_lp-1:0]      cnt_r, cnt_n;
    logic [vaddr_width_p-1:0] entry_r [ras_els_p];

    logic [qp_w_lp-1:0]       rptr_r, rptr_n, wptr_r, wptr_n;
    logic [ptr_w_lp-1:0]      slot_ptr_r [ckpt_els_p];
    logic [cnt_w_lp-1:0]      slot_cnt_r [ckpt_els_p];
    logic [vaddr_width_p-1:0] slot_pc_r  [ckpt_els_p];

    logic                        q_empty, q_full, ckpt_fire, commit_fire;
    logic                        wr_en;
    logic [vaddr_width_p-1:0]    wr_data, ckpt_pc, empty_pc;
    logic [ckpt_id_width_lp-1:0] rst_dist;
    logic [qp_w_lp-1:0]          q_occ;

    function automatic logic [cnt_w_lp-1:0] sat_inc(input logic [cnt_w_lp-1:0] c);
        return (c == cnt_w_lp'(ras_els_p)) ? c : c + cnt_w_lp'(1);
    endfunction

    assign q_occ        = wptr_r - rptr_r;
    assign q_empty      = (rptr_r == wptr_r);
    assign q_full       = (rptr_r[ckpt_id_width_lp-1:0] == wptr_r[ckpt_id_width_lp-1:0])
                        && (rptr_r[ckpt_id_width_lp] != wptr_r[ckpt_id_width_lp]);
    assign ckpt_ready_o = ~q_full & ~restore_v_i;
    assign ckpt_id_o    = wptr_r[ckpt_id_width_lp-1:0];
    assign ckpt_fire    = ckpt_v_i & ckpt_ready_o;
    assign commit_fire  = commit_v_i & ~q_empty;
    assign rst_dist     = restore_id_i - rptr_r[ckpt_id_width_lp-1:0];

    // Next stack state; every write lands at ptr_n, so the checkpoint payload can bypass it.
    always_comb begin
        ptr_n   = ptr_r;
        cnt_n   = cnt_r;
        wr_en   = 1'b0;
        wr_data = push_pc_i;
        if (restore_v_i) begin
            ptr_n   = slot_ptr_r[restore_id_i];
            cnt_n   = slot_cnt_r[restore_id_i];
            wr_en   = 1'b1;
            wr_data = slot_pc_r[restore_id_i];
        end else if (push_v_i && pop_v_i && (cnt_r != '0)) begin
            wr_en = 1'b1;
        end else if (push_v_i) begin
            ptr_n = ptr_r + ptr_w_lp'(1);
            cnt_n = sat_inc(cnt_r);
            wr_en = 1'b1;
        end else if (pop_v_i && (cnt_r != '0)) begin
            ptr_n = ptr_r - ptr_w_lp'(1);
            cnt_n = cnt_r - cnt_w_lp'(1);
        end
    end

    assign ckpt_pc = wr_en ? wr_data : entry_r[ptr_n];

    // Restore frees everything younger than the named slot; wptr's wrap bit follows from distance to rptr.
    always_comb begin
        rptr_n = rptr_r + qp_w_lp'(commit_fire);
        wptr_n = wptr_r + qp_w_lp'(ckpt_fire);
        if (restore_v_i)
            wptr_n = rptr_r + {1'b0, rst_dist} + qp_w_lp'(1);
    end

`ifdef BP_FE_RAS_CKPT_BACKUP_EN
    logic [vaddr_width_p-1:0] backup_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            backup_r <= '0;
        else if (push_v_i && !restore_v_i)
            backup_r <= push_pc_i;
    end

    assign empty_pc = backup_r;
`else
    assign empty_pc = '0;
`endif

    assign pop_pc_v_o = (cnt_r != '0);
    assign pop_pc_o   = pop_pc_v_o ? entry_r[ptr_r] : empty_pc;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r  <= '0;
            cnt_r  <= '0;
            rptr_r <= '0;
            wptr_r <= '0;
        end else begin
            ptr_r  <= ptr_n;
            cnt_r  <= cnt_n;
            rptr_r <= rptr_n;
            wptr_r <= wptr_n;
        end
    end

    // Storage arrays are not reset, but reset still suppresses writes.
    always_ff @(posedge clk_i) begin
        if (!reset_i && wr_en)
            entry_r[ptr_n] <= wr_data;
        if (!reset_i && ckpt_fire) begin
            slot_ptr_r[ckpt_id_o] <= ptr_n;
            slot_cnt_r[ckpt_id_o] <= cnt_n;
            slot_pc_r[ckpt_id_o]  <= ckpt_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(commit_v_i && q_empty))
                else $error("bp_fe_ras_ckpt: commit with no live checkpoint");
            assert (!restore_v_i || ({1'b0, rst_dist} < q_occ))
                else $error("bp_fe_ras_ckpt: restore of a checkpoint that is not live");
        end
    end

endmodule

// File: tb/tb_bp_fe_ras_ckpt.sv
// Testbench for bp_fe_ras_ckpt: directed test-plan scenarios plus randomized traffic against a queue-based model.
module tb_bp_fe_ras_ckpt;
    localparam int VW = 39;
    localparam int RE = 4;
    localparam int CE = 2;
    localparam int IW = 1;

    logic          clk_i = 1'b0;
    logic          reset_i, push_v_i, pop_v_i, ckpt_v_i, commit_v_i, restore_v_i;
    logic [VW-1:0] push_pc_i, pop_pc_o;
    logic          pop_pc_v_o, ckpt_ready_o;
    logic [IW-1:0] ckpt_id_o, restore_id_i;

    always #5 clk_i = ~clk_i;

    bp_fe_ras_ckpt #(.vaddr_width_p(VW), .ras_els_p(RE), .ckpt_els_p(CE)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .push_v_i(push_v_i), .push_pc_i(push_pc_i),
        .pop_v_i(pop_v_i), .pop_pc_o(pop_pc_o), .pop_pc_v_o(pop_pc_v_o),
        .ckpt_v_i(ckpt_v_i), .ckpt_ready_o(ckpt_ready_o), .ckpt_id_o(ckpt_id_o),
        .commit_v_i(commit_v_i), .restore_v_i(restore_v_i), .restore_id_i(restore_id_i)
    );

    int checks = 0;
    int errors = 0;

    // Model: circular stack of return addresses; live checkpoints as an ordered list of ids.
    logic [VW-1:0] m_mem [RE];
    int            m_ptr, m_cnt, m_next;
    logic [VW-1:0] m_backup;
    int            s_ptr [CE];
    int            s_cnt [CE];
    logic [VW-1:0] s_pc  [CE];
    int            live [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] exp_pc();
        if (m_cnt != 0) return m_mem[m_ptr];
`ifdef BP_FE_RAS_CKPT_BACKUP_EN
        return m_backup;
`else
        return '0;
`endif
    endfunction

    task automatic compare_all();
        chk("pop_pc_v_o", 64'(pop_pc_v_o), 64'(m_cnt != 0));
        chk("pop_pc_o", 64'(pop_pc_o), 64'(exp_pc()));
        chk("ckpt_ready_o", 64'(ckpt_ready_o), 64'((live.size() < CE) && !restore_v_i));
        chk("ckpt_id_o", 64'(ckpt_id_o), 64'(m_next));
    endtask

    task automatic model_update();
        bit can_commit;
        int rid;
        if (reset_i) begin
            m_ptr = 0; m_cnt = 0; m_next = 0; m_backup = '0;
            live.delete();
            return;
        end
        can_commit = (live.size() > 0);
        if (restore_v_i) begin
            rid   = int'(restore_id_i);
            m_ptr = s_ptr[rid];
            m_cnt = s_cnt[rid];
            m_mem[m_ptr] = s_pc[rid];
            while (live.size() > 0 && live[$] != rid) void'(live.pop_back());
            m_next = (rid + 1) % CE;
        end else begin
            if (push_v_i && pop_v_i && m_cnt > 0) begin
                m_mem[m_ptr] = push_pc_i;
            end else if (push_v_i) begin
                m_ptr = (m_ptr + 1) % RE;
                m_mem[m_ptr] = push_pc_i;
                if (m_cnt < RE) m_cnt++;
            end else if (pop_v_i && m_cnt > 0) begin
                m_ptr = (m_ptr + RE - 1) % RE;
                m_cnt--;
            end
            if (push_v_i) m_backup = push_pc_i;
            if (ckpt_v_i && live.size() < CE) begin
                s_ptr[m_next] = m_ptr;
                s_cnt[m_next] = m_cnt;
                s_pc[m_next]  = m_mem[m_ptr];
                live.push_back(m_next);
                m_next = (m_next + 1) % CE;
            end
        end
        if (commit_v_i && can_commit) void'(live.pop_front());
    endtask

    task automatic set_in(input bit psh, input logic [VW-1:0] pc, input bit pp, input bit ck,
                          input bit cm, input bit rs, input int rid);
        reset_i      = 1'b0;
        push_v_i     = psh;
        push_pc_i    = pc;
        pop_v_i      = pp;
        ckpt_v_i     = ck;
        commit_v_i   = cm;
        restore_v_i  = rs;
        restore_id_i = IW'(rid);
    endtask

    // Inputs already applied at a negedge: check, clock, advance model.
    task automatic cyc();
        #1;
        compare_all();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic peek();
        set_in(0, '0, 0, 0, 0, 0, 0);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, '0, 0, 0, 0, 0, 0);
        reset_i = 1'b1;
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic push(input logic [VW-1:0] pc); set_in(1, pc, 0, 0, 0, 0, 0); cyc(); endtask
    task automatic pop();                         set_in(0, '0, 1, 0, 0, 0, 0); cyc(); endtask

    logic [VW-1:0] empty_exp;

    initial begin
`ifdef BP_FE_RAS_CKPT_BACKUP_EN
        empty_exp = VW'(64'h200);
`else
        empty_exp = '0;
`endif
        do_reset();
        // Reset state
        peek();
        chk("rst_v", 64'(pop_pc_v_o), 64'd0);
        chk("rst_pc", 64'(pop_pc_o), 64'd0);
        chk("rst_ready", 64'(ckpt_ready_o), 64'd1);
        chk("rst_id", 64'(ckpt_id_o), 64'd0);
        cyc();

        // Basic order
        push(VW'(64'h100)); push(VW'(64'h200));
        peek(); chk("basic_top0", 64'(pop_pc_o), 64'h200); chk("basic_v0", 64'(pop_pc_v_o), 64'd1);
        pop();
        peek(); chk("basic_top1", 64'(pop_pc_o), 64'h100); chk("basic_v1", 64'(pop_pc_v_o), 64'd1);
        pop();
        peek(); chk("basic_v2", 64'(pop_pc_v_o), 64'd0); chk("basic_pc2", 64'(pop_pc_o), 64'(empty_exp));
        pop();
        peek(); chk("basic_v3", 64'(pop_pc_v_o), 64'd0);

        // Overflow
        do_reset();
        for (int i = 1; i <= 5; i++) push(VW'(i * 16));
        for (int i = 5; i >= 2; i--) begin
            peek(); chk("ovf_top", 64'(pop_pc_o), 64'(i * 16)); chk("ovf_v", 64'(pop_pc_v_o), 64'd1);
            pop();
        end
        peek(); chk("ovf_empty", 64'(pop_pc_v_o), 64'd0);

        // Checkpoint / restore
        do_reset();
        set_in(1, VW'(64'hA0), 0, 1, 0, 0, 0);
        #1; chk("ck_id0", 64'(ckpt_id_o), 64'd0); chk("ck_rdy0", 64'(ckpt_ready_o), 64'd1);
        cyc();
        push(VW'(64'hB0)); pop(); pop(); push(VW'(64'hC0));
        set_in(0, '0, 0, 0, 0, 1, 0);
        #1; chk("rs_rdy", 64'(ckpt_ready_o), 64'd0);
        cyc();
        peek(); chk("rs_top", 64'(pop_pc_o), 64'hA0); chk("rs_v", 64'(pop_pc_v_o), 64'd1);
        pop();
        peek(); chk("rs_pop_v", 64'(pop_pc_v_o), 64'd0);

        // Queue full / wrap
        do_reset();
        set_in(0, '0, 0, 1, 0, 0, 0); cyc();
        set_in(0, '0, 0, 1, 0, 0, 0); #1; chk("q_id1", 64'(ckpt_id_o), 64'd1); cyc();
        peek(); chk("q_full_rdy", 64'(ckpt_ready_o), 64'd0);
        set_in(0, '0, 0, 0, 1, 0, 0); cyc();
        peek(); chk("q_commit_rdy", 64'(ckpt_ready_o), 64'd1); chk("q_commit_id", 64'(ckpt_id_o), 64'd0);
        set_in(0, '0, 0, 0, 0, 1, 1); cyc();
        peek(); chk("q_restore_id", 64'(ckpt_id_o), 64'd0); chk("q_restore_rdy", 64'(ckpt_ready_o), 64'd1);

        // Simultaneous events
        do_reset();
        push(VW'(64'h100)); push(VW'(64'h200));
        set_in(1, VW'(64'h300), 1, 0, 0, 0, 0); cyc();
        peek(); chk("sim_top", 64'(pop_pc_o), 64'h300);
        pop();
        peek(); chk("sim_below", 64'(pop_pc_o), 64'h100);
        set_in(0, '0, 0, 1, 0, 0, 0); cyc();
        set_in(1, VW'(64'h400), 0, 0, 0, 1, 0);
        #1; chk("sim_rs_rdy", 64'(ckpt_ready_o), 64'd0);
        cyc();
        peek(); chk("sim_rs_top", 64'(pop_pc_o), 64'h100); chk("sim_rs_v", 64'(pop_pc_v_o), 64'd1);

        // Backup behaviour when empty
        do_reset();
        push(VW'(64'h44)); pop();
        peek();
        chk("bk_v", 64'(pop_pc_v_o), 64'd0);
`ifdef BP_FE_RAS_CKPT_BACKUP_EN
        chk("bk_pc", 64'(pop_pc_o), 64'h44);
`else
        chk("bk_pc", 64'(pop_pc_o), 64'd0);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit psh, pp, ck, cm, rs;
            int rid;
            logic [VW-1:0] pc;
            pc  = VW'({$urandom(), $urandom()});
            psh = ($urandom_range(0, 99) < 45);
            pp  = ($urandom_range(0, 99) < 40);
            ck  = ($urandom_range(0, 99) < 35);
            cm  = (live.size() > 0) && ($urandom_range(0, 99) < 25);
            rs  = (live.size() > 0) && ($urandom_range(0, 99) < 12);
            rid = rs ? live[$urandom_range(0, live.size() - 1)] : int'($urandom_range(0, CE - 1));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                set_in(psh, pc, pp, ck, cm, rs, rid);
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
